arb2_4: RTL

- Two-requester arbiter and sequencer that shares one 4-bit datapath between sources A and B.
- It drives the select line of the existing mux2_4 instance and registers the selected nibble into a one-entry output buffer.
- The output buffer uses a valid/ready handshake toward the consumer.
- Round-robin fairness, with a bounded burst length per grant.

---
 rtl/arb2_4_pkg.sv | 18 +
 rtl/mux2_4.sv | 14 +
 rtl/arb2_4.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arb2_4_pkg.sv
// Shared types and constants for the two-source nibble arbiter.
package arb2_4_pkg;

  // Arbiter grant states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  // Mux select encoding; also used to remember which source was served last.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Burst counter width; wide enough for MAX_BURST up to 15.
  localparam int BURST_W = 4;

endpackage

// File: rtl/mux2_4.sv
// 4-bit two-input data mux: y = a when sel = 0, b when sel = 1.
module mux2_4 (
  input  logic       sel,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);

  // Pure combinational selection.
  always_comb begin
    y = sel ? b : a;
  end

endmodule

// File: rtl/arb2_4.sv
// Round-robin arbiter for two nibble sources with a bounded burst per grant,
// feeding a one-entry valid/ready output buffer through mux2_4.
//
// state | meaning
// IDLE  | no grant; choose a source when one or both request
// GNT_A | source A owns the datapath, s = 0
// GNT_B | source B owns the datapath, s = 1
module arb2_4
  import arb2_4_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqA,
  input  logic [3:0] A,
  output logic       ackA,
  input  logic       reqB,
  input  logic [3:0] B,
  output logic       ackB,
  output logic       s,
  output logic [3:0] Out,
  output logic       valid_out,
  input  logic       ready_out
);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [3:0]         out_q, out_d;
  logic               valid_q, valid_d;

  logic               slot_free;
  logic               burst_at_last;
  logic [3:0]         mux_y;

  mux2_4 u_mux (
    .sel (s),
    .a   (A),
    .b   (B),
    .y   (mux_y)
  );

  // Handshake and select decode from the current grant and buffer occupancy.
  always_comb begin
    slot_free     = !valid_q || ready_out;
    s             = (state_q == GNT_B) ? SEL_B : SEL_A;
    ackA          = (state_q == GNT_A) && reqA && slot_free;
    ackB          = (state_q == GNT_B) && reqB && slot_free;
    burst_at_last = (burst_cnt_q == BURST_LAST);
    Out           = out_q;
    valid_out     = valid_q;
  end

  // Next grant, burst count and output buffer contents.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    out_d       = out_q;
    valid_d     = valid_q;

    unique case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (reqA && reqB) begin
          state_d = (last_q == SEL_B) ? GNT_A : GNT_B;
        end else if (reqA) begin
          state_d = GNT_A;
        end else if (reqB) begin
          state_d = GNT_B;
        end
      end

      GNT_A: begin
        if (!reqA) begin
          state_d     = reqB ? GNT_B : IDLE;
          last_d      = SEL_A;
          burst_cnt_d = '0;
        end else if (ackA) begin
          if (reqB && burst_at_last) begin
            state_d     = GNT_B;
            last_d      = SEL_A;
            burst_cnt_d = '0;
          end else if (!burst_at_last) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end
      end

      GNT_B: begin
        if (!reqB) begin
          state_d     = reqA ? GNT_A : IDLE;
          last_d      = SEL_B;
          burst_cnt_d = '0;
        end else if (ackB) begin
          if (reqA && burst_at_last) begin
            state_d     = GNT_A;
            last_d      = SEL_B;
            burst_cnt_d = '0;
          end else if (!burst_at_last) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase

    // A transfer refills the buffer even when the old entry drains this cycle.
    if (ackA || ackB) begin
      out_d   = mux_y;
      valid_d = 1'b1;
    end else if (ready_out) begin
      valid_d = 1'b0;
    end
  end

  // State and buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= SEL_B;
      burst_cnt_q <= '0;
      out_q       <= 4'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
    end
  end

endmodule
